writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 117 +++++++++++
 tb/tb_writeback_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Y86-64 writeback stage: M/W pipeline register, 15-entry register file and
// sticky halt flag. Register reads are combinational and show pre-edge state.
module writeback_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  m_stat,
  input  logic [3:0]  m_icode,
  input  logic [3:0]  m_dstE,
  input  logic [3:0]  m_dstM,
  input  logic [63:0] m_valE,
  input  logic [63:0] m_valM,
  input  logic        W_stall,
  input  logic        W_bubble,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output logic [63:0] rvalA,
  output logic [63:0] rvalB,
  output logic [2:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic        halted
);

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STAT_W = 3;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned NREGS  = 15;

  localparam logic [STAT_W-1:0] STAT_AOK  = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_HLT  = STAT_W'(2);
  localparam logic [STAT_W-1:0] STAT_ADR  = STAT_W'(3);
  localparam logic [STAT_W-1:0] STAT_INS  = STAT_W'(4);
  localparam logic [CODE_W-1:0] ICODE_NOP = CODE_W'(1);
  localparam logic [REG_W-1:0]  RNONE     = REG_W'(15);

  typedef struct packed {
    logic [STAT_W-1:0] stat;
    logic [CODE_W-1:0] icode;
    logic [REG_W-1:0]  dst_e;
    logic [REG_W-1:0]  dst_m;
    logic [XLEN-1:0]   val_e;
    logic [XLEN-1:0]   val_m;
  } mw_t;

  localparam mw_t MW_NOP = '{stat: STAT_AOK, icode: ICODE_NOP, dst_e: RNONE,
                             dst_m: RNONE, val_e: '0, val_m: '0};

  mw_t             mw_q, mw_d, m_in;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  logic            halted_q, halted_d;
  logic            wr_en;

  // Bundle the memory-stage inputs into one payload
  always_comb begin
    m_in = '{stat: m_stat, icode: m_icode, dst_e: m_dstE, dst_m: m_dstM,
             val_e: m_valE, val_m: m_valM};
  end

  // M/W next state: frozen when halted, stall beats bubble
  always_comb begin
    mw_d = mw_q;
    if (!halted_q && !W_stall) begin
      mw_d = W_bubble ? MW_NOP : m_in;
    end
  end

  // Register-file next state; valM is applied last so it wins a dstE==dstM tie
  always_comb begin
    wr_en = (mw_q.stat == STAT_AOK) && !halted_q;
    for (int i = 0; i < NREGS; i++) begin
      rf_d[i] = rf_q[i];
      if (wr_en && (mw_q.dst_e == REG_W'(i))) rf_d[i] = mw_q.val_e;
      if (wr_en && (mw_q.dst_m == REG_W'(i))) rf_d[i] = mw_q.val_m;
    end
  end

  // Halt is sticky once an exceptional status reaches writeback
  always_comb begin
    halted_d = halted_q;
    if ((mw_q.stat == STAT_HLT) || (mw_q.stat == STAT_ADR) || (mw_q.stat == STAT_INS)) begin
      halted_d = 1'b1;
    end
  end

  // State registers with asynchronous reset to a nop / cleared file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mw_q     <= MW_NOP;
      halted_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      mw_q     <= mw_d;
      halted_q <= halted_d;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
    end
  end

  // Combinational reads; RNONE reads as zero
  always_comb begin
    rvalA = (srcA == RNONE) ? '0 : rf_q[srcA];
    rvalB = (srcB == RNONE) ? '0 : rf_q[srcB];
  end

  assign W_stat  = mw_q.stat;
  assign W_icode = mw_q.icode;
  assign W_dstE  = mw_q.dst_e;
  assign W_dstM  = mw_q.dst_m;
  assign W_valE  = mw_q.val_e;
  assign W_valM  = mw_q.val_m;
  assign halted  = halted_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus random traffic compared
// against an architectural model of the M/W register, register file and halt.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode, m_dstE, m_dstM;
  logic [63:0] m_valE, m_valM;
  logic        W_stall, W_bubble;
  logic [3:0]  srcA, srcB;
  logic [63:0] rvalA, rvalB;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode, W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  logic        halted;

  int errors = 0;
  int checks = 0;

  writeback_stage dut (
    .clk(clk), .rst(rst),
    .m_stat(m_stat), .m_icode(m_icode), .m_dstE(m_dstE), .m_dstM(m_dstM),
    .m_valE(m_valE), .m_valM(m_valM),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .srcA(srcA), .srcB(srcB), .rvalA(rvalA), .rvalB(rvalB),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM), .halted(halted)
  );

  always #5 clk = ~clk;

  // Architectural model state
  logic [63:0] ref_rf [15];
  logic [2:0]  r_stat;
  logic [3:0]  r_icode, r_dste, r_dstm;
  logic [63:0] r_vale, r_valm;
  logic        r_halted;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_read(input logic [3:0] a);
    return (a == 4'hF) ? 64'd0 : ref_rf[a];
  endfunction

  task automatic ref_nop();
    r_stat = 3'd1; r_icode = 4'd1; r_dste = 4'hF; r_dstm = 4'hF;
    r_vale = 64'd0; r_valm = 64'd0;
  endtask

  task automatic ref_reset();
    ref_nop();
    r_halted = 1'b0;
    for (int i = 0; i < 15; i++) ref_rf[i] = 64'd0;
  endtask

  // One clock edge of the architecture, using pre-edge values throughout
  task automatic ref_edge();
    logic was_halted;
    was_halted = r_halted;
    if (r_stat == 3'd1 && !was_halted) begin
      if (r_dste != 4'hF) ref_rf[r_dste] = r_vale;
      if (r_dstm != 4'hF) ref_rf[r_dstm] = r_valm;
    end
    if (r_stat >= 3'd2 && r_stat <= 3'd4) r_halted = 1'b1;
    if (!was_halted && !W_stall) begin
      if (W_bubble) ref_nop();
      else begin
        r_stat = m_stat; r_icode = m_icode; r_dste = m_dstE; r_dstm = m_dstM;
        r_vale = m_valE; r_valm = m_valM;
      end
    end
  endtask

  task automatic check_all();
    check("W_stat",  64'(W_stat),  64'(r_stat));
    check("W_icode", 64'(W_icode), 64'(r_icode));
    check("W_dstE",  64'(W_dstE),  64'(r_dste));
    check("W_dstM",  64'(W_dstM),  64'(r_dstm));
    check("W_valE",  W_valE, r_vale);
    check("W_valM",  W_valM, r_valm);
    check("halted",  64'(halted), 64'(r_halted));
    check("rvalA",   rvalA, ref_read(srcA));
    check("rvalB",   rvalB, ref_read(srcB));
  endtask

  task automatic step();
    @(posedge clk);
    ref_edge();
    #1;
    check_all();
  endtask

  task automatic set_m(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] de,
                       input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    m_stat = st; m_icode = ic; m_dstE = de; m_dstM = dm; m_valE = ve; m_valM = vm;
  endtask

  // Mid-cycle reset pulse, checked before any clock edge occurs
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    ref_reset();
    check("arst_W_icode", 64'(W_icode), 64'd1);
    check("arst_halted",  64'(halted), 64'd0);
    check("arst_rvalA",   rvalA, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_all();
  endtask

  task automatic random_phase(input int n, input bit allow_halt);
    int r;
    for (int k = 0; k < n; k++) begin
      r = int'($urandom_range(0, 15));
      if (r < 12) m_stat = 3'd1;
      else if (allow_halt && r == 15) m_stat = 3'($urandom_range(2, 4));
      else begin
        r = int'($urandom_range(0, 3));
        m_stat = (r == 0) ? 3'd0 : 3'(r + 4);
      end
      m_icode = 4'($urandom_range(0, 15));
      m_dstE  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      m_dstM  = ($urandom_range(0, 2) == 0) ? m_dstE :
                (($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14)));
      m_valE  = {$urandom, $urandom};
      m_valM  = {$urandom, $urandom};
      W_stall  = ($urandom_range(0, 6) == 0);
      W_bubble = ($urandom_range(0, 6) == 0);
      srcA = 4'($urandom_range(0, 15));
      srcB = 4'($urandom_range(0, 15));
      step();
    end
    W_stall = 1'b0; W_bubble = 1'b0;
  endtask

  initial begin
    rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0; srcA = 4'd0; srcB = 4'hF;
    set_m(3'd1, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0);
    ref_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_W_stat",  64'(W_stat),  64'd1);
    check("rst_W_icode", 64'(W_icode), 64'd1);
    check("rst_W_dstE",  64'(W_dstE),  64'hF);
    check("rst_halted",  64'(halted),  64'd0);
    check_all();
    rst = 1'b0;

    // irmovq into %rdx: visible on W after one edge, in the file after two
    set_m(3'd1, 4'd3, 4'd2, 4'hF, 64'h1234, 64'd0);
    srcA = 4'd2;
    step();
    check("irmovq_W_valE", W_valE, 64'h1234);
    check("irmovq_prewrite", rvalA, 64'd0);
    set_m(3'd1, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0);
    step();
    check("irmovq_rvalA", rvalA, 64'h1234);

    // popq %rsp: valM wins over valE
    set_m(3'd1, 4'hB, 4'd4, 4'd4, 64'h108, 64'hAA);
    step();
    set_m(3'd1, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0);
    srcA = 4'd4;
    step();
    check("popq_rsp", rvalA, 64'hAA);

    // Stall holds, bubble inserts nop, stall beats bubble
    set_m(3'd1, 4'd6, 4'd5, 4'hF, 64'h99, 64'd0);
    step();
    set_m(3'd1, 4'd2, 4'd7, 4'hF, 64'h11, 64'd0);
    W_stall = 1'b1;
    step();
    check("stall_hold_icode", 64'(W_icode), 64'd6);
    W_stall = 1'b0; W_bubble = 1'b1;
    step();
    check("bubble_icode", 64'(W_icode), 64'd1);
    check("bubble_dstE",  64'(W_dstE),  64'hF);
    W_bubble = 1'b0;
    step();
    set_m(3'd1, 4'd7, 4'd8, 4'hF, 64'h22, 64'd0);
    W_stall = 1'b1; W_bubble = 1'b1;
    step();
    check("stall_bubble_hold", 64'(W_icode), 64'd2);
    W_stall = 1'b0; W_bubble = 1'b0;

    // RNONE destinations change nothing
    set_m(3'd1, 4'd3, 4'hF, 4'hF, 64'h77, 64'd0);
    step();
    step();
    srcA = 4'hF; srcB = 4'd2;
    #1;
    check("rnone_rvalA", rvalA, 64'd0);
    check("rnone_reg2",  rvalB, 64'h1234);

    random_phase(300, 1'b0);

    async_reset();
    // Load %rcx, then halt with a pending write to %rbx
    set_m(3'd1, 4'd3, 4'd1, 4'hF, 64'h55, 64'd0);
    step();
    set_m(3'd1, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0);
    srcA = 4'd1;
    step();
    check("load_reg1", rvalA, 64'h55);
    set_m(3'd2, 4'd0, 4'd3, 4'hF, 64'd5, 64'd0);
    step();
    set_m(3'd1, 4'd3, 4'd3, 4'hF, 64'd9, 64'd0);
    srcA = 4'd3;
    step();
    check("halt_set", 64'(halted), 64'd1);
    check("halt_reg3", rvalA, 64'd0);
    W_bubble = 1'b1;
    step();
    W_bubble = 1'b0;
    step();
    step();
    check("halt_frozen_icode", 64'(W_icode), 64'd3);
    check("halt_reg3_after", rvalA, 64'd0);
    srcA = 4'd1;
    #1;
    check("halt_read_reg1", rvalA, 64'h55);
    async_reset();

    random_phase(200, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
